// File: rtl/hdmi_pkg.sv
// Shared types and default settings for the HDMI PLL control logic.
package hdmi_pkg;

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_READY      = 3'd3,
    ST_FAIL       = 3'd4
  } pll_state_e;

  // Analog settings for the 74.25 MHz in / 371.25 MHz serial-clock configuration.
  localparam logic [5:0] HDMI_ICP_SEL = 6'd0;
  localparam logic [2:0] HDMI_LPF_RES = 3'd0;
  localparam logic [1:0] HDMI_LPF_CAP = 2'd0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous status inputs; resets to zero.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hdmi_pll_ctrl.sv
// Bring-up / supervision sequencer for the HDMI PLL: reset hold, lock
// qualification, bounded retry and a single clean ready flag.
//
// state      | meaning
// RESET_HOLD | PLL reset asserted for RST_CYCLES
// WAIT_LOCK  | reset released, waiting for synced lock (bounded)
// STABLE     | lock seen, must stay high STABLE_CYCLES in a row
// READY      | qualified lock published; lock loss re-runs bring-up
// FAIL       | retries exhausted, PLL held in reset until restart
module hdmi_pll_ctrl
  import hdmi_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 64,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 3,
  parameter logic [5:0]  ICP_SEL       = HDMI_ICP_SEL,
  parameter logic [2:0]  LPF_RES       = HDMI_LPF_RES,
  parameter logic [1:0]  LPF_CAP       = HDMI_LPF_CAP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock_i,
  input  logic       restart_i,
  output logic       pll_reset_o,
  output logic [5:0] icpsel_o,
  output logic [2:0] lpfres_o,
  output logic [1:0] lpfcap_o,
  output logic       pll_ready_o,
  output logic       pll_fail_o,
  output logic [3:0] retry_cnt_o
);

  localparam int TMR_MAX = max3(int'(RST_CYCLES), int'(LOCK_TIMEOUT), int'(STABLE_CYCLES));
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] RST_TC    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_TC   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_TC = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

  logic             w_lock_s;
  pll_state_e       r_state;
  pll_state_e       w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic             w_tmr_clr;
  logic [3:0]       r_retry;
  logic [3:0]       w_retry_nxt;
  logic             w_fail_evt;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_lock_i),
    .o_q   (w_lock_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RESET_HOLD;
      r_retry <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_fail_evt  = 1'b0;

    case (r_state)
      ST_RESET_HOLD: begin
        if (r_tmr == RST_TC) w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s)              w_state_nxt = ST_STABLE;
        else if (r_tmr == LOCK_TC) w_fail_evt  = 1'b1;
      end
      ST_STABLE: begin
        if (!w_lock_s) begin
          w_fail_evt = 1'b1;
        end else if (r_tmr == STABLE_TC) begin
          w_state_nxt = ST_READY;
          w_retry_nxt = 4'd0;
        end
      end
      ST_READY: begin
        // Lock loss after qualification is a re-bring-up, not a failed attempt.
        if (!w_lock_s) w_state_nxt = ST_RESET_HOLD;
      end
      ST_FAIL: begin
        w_state_nxt = ST_FAIL;
      end
      default: begin
        w_state_nxt = ST_RESET_HOLD;
      end
    endcase

    if (w_fail_evt) begin
      if ({1'b0, r_retry} + 5'd1 >= 5'(MAX_RETRY)) begin
        w_state_nxt = ST_FAIL;
        w_retry_nxt = RETRY_LIM;
      end else begin
        w_state_nxt = ST_RESET_HOLD;
        w_retry_nxt = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;
      end
    end

    // Restart overrides everything, including a same-cycle timeout or lock loss.
    if (restart_i) begin
      w_state_nxt = ST_RESET_HOLD;
      w_retry_nxt = 4'd0;
    end
  end

  assign w_tmr_clr = restart_i || (w_state_nxt != r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
    end else if (w_tmr_clr) begin
      r_tmr <= '0;
    end else if (r_tmr != {TMR_W{1'b1}}) begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

  assign pll_reset_o = (r_state == ST_RESET_HOLD) || (r_state == ST_FAIL);
  assign pll_ready_o = (r_state == ST_READY);
  assign pll_fail_o  = (r_state == ST_FAIL);
  assign retry_cnt_o = r_retry;

  assign icpsel_o = ICP_SEL;
  assign lpfres_o = LPF_RES;
  assign lpfcap_o = LPF_CAP;

endmodule

// File: tb/tb_hdmi_pll_ctrl.sv
// Directed bench for hdmi_pll_ctrl: phase-level reference model checked every
// cycle, plus hand-computed expectations at key cycles.
module tb_hdmi_pll_ctrl;

  localparam int          RST_CYCLES    = 4;
  localparam int          LOCK_TIMEOUT  = 20;
  localparam int          STABLE_CYCLES = 8;
  localparam int          MAX_RETRY     = 2;
  localparam logic [5:0]  TB_ICP        = 6'd37;
  localparam logic [2:0]  TB_RES        = 3'd5;
  localparam logic [1:0]  TB_CAP        = 2'd2;

  logic       clk;
  logic       rst_n;
  logic       pll_lock_i;
  logic       restart_i;
  logic       pll_reset_o;
  logic [5:0] icpsel_o;
  logic [2:0] lpfres_o;
  logic [1:0] lpfcap_o;
  logic       pll_ready_o;
  logic       pll_fail_o;
  logic [3:0] retry_cnt_o;

  hdmi_pll_ctrl #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRY     (MAX_RETRY),
    .ICP_SEL       (TB_ICP),
    .LPF_RES       (TB_RES),
    .LPF_CAP       (TB_CAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock_i  (pll_lock_i),
    .restart_i   (restart_i),
    .pll_reset_o (pll_reset_o),
    .icpsel_o    (icpsel_o),
    .lpfres_o    (lpfres_o),
    .lpfcap_o    (lpfcap_o),
    .pll_ready_o (pll_ready_o),
    .pll_fail_o  (pll_fail_o),
    .retry_cnt_o (retry_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: the PLL is in one of five phases; each phase lasts a
  // number of cycles and ends on the synced lock level seen two edges late.
  localparam int P_DEAD = 7, P_HOLD = 10, P_WAIT = 20, P_QUAL = 30, P_UP = 40;
  int m_phase, m_age, m_retries, cyc;
  bit m_s1, m_s2, m_ls;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_HOLD; m_age = 0; m_retries = 0;
      m_s1 = 0; m_s2 = 0; cyc = 0;
    end else begin
      m_ls = m_s2;
      m_s2 = m_s1;
      m_s1 = pll_lock_i;
      cyc++;
      if (restart_i) begin
        m_phase = P_HOLD; m_age = 0; m_retries = 0;
      end else begin
        m_age++;
        case (m_phase)
          P_HOLD: if (m_age == RST_CYCLES) begin m_phase = P_WAIT; m_age = 0; end
          P_WAIT: begin
            if (m_ls) begin m_phase = P_QUAL; m_age = 0; end
            else if (m_age == LOCK_TIMEOUT) m_age = -1;
          end
          P_QUAL: begin
            if (!m_ls) m_age = -1;
            else if (m_age == STABLE_CYCLES) begin m_phase = P_UP; m_age = 0; m_retries = 0; end
          end
          P_UP: if (!m_ls) begin m_phase = P_HOLD; m_age = 0; end
          default: ;
        endcase
        if (m_age == -1) begin
          m_age = 0;
          if (m_retries + 1 >= MAX_RETRY) begin m_retries = MAX_RETRY; m_phase = P_DEAD; end
          else begin m_retries++; m_phase = P_HOLD; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pll_reset", int'(pll_reset_o), int'(m_phase == P_HOLD || m_phase == P_DEAD));
      chk("pll_ready", int'(pll_ready_o), int'(m_phase == P_UP));
      chk("pll_fail",  int'(pll_fail_o),  int'(m_phase == P_DEAD));
      chk("retry_cnt", int'(retry_cnt_o), m_retries);
      chk("icpsel",    int'(icpsel_o),    int'(TB_ICP));
      chk("lpfres",    int'(lpfres_o),    int'(TB_RES));
      chk("lpfcap",    int'(lpfcap_o),    int'(TB_CAP));
    end
  end

  task automatic goto(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic lit(input int k, input int rst_e, input int rdy_e, input int fail_e, input int rc_e);
    goto(k);
    chk($sformatf("c%0d_reset", k), int'(pll_reset_o), rst_e);
    chk($sformatf("c%0d_ready", k), int'(pll_ready_o), rdy_e);
    chk($sformatf("c%0d_fail", k),  int'(pll_fail_o),  fail_e);
    chk($sformatf("c%0d_retry", k), int'(retry_cnt_o), rc_e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pll_lock_i = 1'b0; restart_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("in_reset_reset", int'(pll_reset_o), 1);
    chk("in_reset_ready", int'(pll_ready_o), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // Clean bring-up
    lit(0, 1, 0, 0, 0);
    lit(3, 1, 0, 0, 0);
    lit(4, 0, 0, 0, 0);
    goto(10); pll_lock_i = 1'b1;
    lit(20, 0, 0, 0, 0);
    lit(21, 0, 1, 0, 0);

    // Lock loss in READY and relock
    goto(25); pll_lock_i = 1'b0;
    lit(27, 0, 1, 0, 0);
    lit(28, 1, 0, 0, 0);
    goto(30); pll_lock_i = 1'b1;
    lit(40, 0, 0, 0, 0);
    lit(41, 0, 1, 0, 0);

    // Glitch at STABLE cycle 5 (STABLE entered at 53)
    goto(45); pll_lock_i = 1'b0;
    goto(50); pll_lock_i = 1'b1;
    goto(58); pll_lock_i = 1'b0;
    goto(59); pll_lock_i = 1'b1;
    lit(60, 0, 0, 0, 0);
    lit(61, 1, 0, 0, 1);
    lit(73, 0, 0, 0, 1);
    lit(74, 0, 1, 0, 0);

    // Never locks: two attempts then FAIL
    goto(80); pll_lock_i = 1'b0;
    lit(106, 0, 0, 0, 0);
    lit(107, 1, 0, 0, 1);
    lit(130, 0, 0, 0, 1);
    lit(131, 1, 0, 1, 2);
    lit(140, 1, 0, 1, 2);

    // Restart from FAIL, then restart colliding with a WAIT_LOCK timeout
    restart_i = 1'b1;
    goto(141); restart_i = 1'b0;
    lit(141, 1, 0, 0, 0);
    lit(164, 0, 0, 0, 0);
    restart_i = 1'b1;
    goto(165); restart_i = 1'b0;
    lit(165, 1, 0, 0, 0);
    goto(167); restart_i = 1'b1;
    goto(168); restart_i = 1'b0;
    lit(171, 1, 0, 0, 0);
    lit(172, 0, 0, 0, 0);

    // One timeout to get retry_cnt=1, then async reset mid-STABLE
    lit(192, 1, 0, 0, 1);
    goto(194); pll_lock_i = 1'b1;
    lit(200, 0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", int'(pll_reset_o), 1);
    chk("async_ready", int'(pll_ready_o), 0);
    chk("async_fail",  int'(pll_fail_o),  0);
    chk("async_retry", int'(retry_cnt_o), 0);
    chk("async_icp",   int'(icpsel_o),    int'(TB_ICP));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Bring-up with lock already high out of reset
    lit(12, 0, 0, 0, 0);
    lit(13, 0, 1, 0, 0);
    goto(20);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
